// File: rtl/spi_cfg_master.sv
// spi_cfg_master: two-port round-robin SPI write master.
// Each grant becomes one 16-bit mode-0 frame {1, addr, data}.
module spi_cfg_master #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_GAP      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    typedef enum logic [2:0] {
        IDLE, SETUP, HIGH, LOW, HOLD, GAP
    } state_t;

    localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic [4:0]  r_edges, w_edges;
    logic [15:0] r_shift, w_shift;
    logic        r_last, w_last;
    logic        r_gnt, w_gnt;
    logic        r_sclk, w_sclk;
    logic        r_copi, w_copi;
    logic        r_ncs, w_ncs;
    logic        r_ack0, w_ack0;
    logic        r_ack1, w_ack1;
    logic        w_hp_done;

    assign w_hp_done = (r_cnt == HP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_edges <= '0;
            r_shift <= '0;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_ncs   <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_edges <= w_edges;
            r_shift <= w_shift;
            r_last  <= w_last;
            r_gnt   <= w_gnt;
            r_sclk  <= w_sclk;
            r_copi  <= w_copi;
            r_ncs   <= w_ncs;
            r_ack0  <= w_ack0;
            r_ack1  <= w_ack1;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 8'd1;
        w_edges = r_edges;
        w_shift = r_shift;
        w_last  = r_last;
        w_gnt   = r_gnt;
        w_sclk  = r_sclk;
        w_copi  = r_copi;
        w_ncs   = r_ncs;
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (req0 || req1) begin
                    // on contention, serve whoever was not granted last
                    w_gnt   = (req0 && req1) ? ~r_last : req1;
                    w_last  = w_gnt;
                    w_shift = w_gnt ? {1'b1, addr1, data1}
                                    : {1'b1, addr0, data0};
                    w_state = SETUP;
                    w_edges = '0;
                    w_ncs   = 1'b0;
                    w_sclk  = 1'b0;
                    w_copi  = w_shift[15];
                end
            end
            SETUP, LOW: begin
                if (w_hp_done) begin
                    w_state = HIGH;
                    w_cnt   = '0;
                    w_sclk  = 1'b1;
                    w_edges = r_edges + 5'd1;
                end
            end
            HIGH: begin
                if (w_hp_done) begin
                    w_cnt  = '0;
                    w_sclk = 1'b0;
                    if (r_edges == 5'd16) begin
                        w_state = HOLD;
                    end else begin
                        w_state = LOW;
                        w_shift = {r_shift[14:0], r_shift[15]};
                        w_copi  = w_shift[15];
                    end
                end
            end
            HOLD: begin
                if (w_hp_done) begin
                    w_state = GAP;
                    w_cnt   = '0;
                    w_ncs   = 1'b1;
                    w_copi  = 1'b0;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                    w_ack0  = ~r_gnt;
                    w_ack1  = r_gnt;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign busy = (r_state != IDLE);
    assign sclk = r_sclk;
    assign copi = r_copi;
    assign ncs  = r_ncs;

endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master: random and directed writes against a
// frame-level reference model and a peripheral register model.
module tb_spi_cfg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0, req1;
    logic [6:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, busy, sclk, copi, ncs;

    logic       b_req0, b_req1;
    logic [6:0] b_addr0, b_addr1;
    logic [7:0] b_data0, b_data1;
    logic       b_ack0, b_ack1, b_busy, b_sclk, b_copi, b_ncs;

    spi_cfg_master dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .sclk(sclk), .copi(copi), .ncs(ncs)
    );

    spi_cfg_master #(.HALF_PERIOD(6), .CS_GAP(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .req1(b_req1),
        .addr0(b_addr0), .addr1(b_addr1),
        .data0(b_data0), .data1(b_data1),
        .ack0(b_ack0), .ack1(b_ack1), .busy(b_busy),
        .sclk(b_sclk), .copi(b_copi), .ncs(b_ncs)
    );

    typedef struct {
        logic [15:0] w;
        int nb;
        int low;
        int fall;
        int rise;
    } frm_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   stab_err = 0;
    frm_t frames[$];
    logic [7:0] p_regs[0:4];
    logic [7:0] m_regs[0:4];
    int   m_last = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI monitor plus peripheral model fed from captured frames
    logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;
    logic [15:0] m_sh = '0;
    int          m_nb = 0, m_low = 0, m_fall = 0;

    always @(negedge clk) begin
        if (!ncs && p_ncs) begin
            m_fall = cyc;
            m_nb = 0;
            m_low = 0;
            m_sh = '0;
        end
        if (!ncs) m_low++;
        if (!ncs && sclk && !p_sclk) begin
            m_sh = {m_sh[14:0], copi};
            m_nb++;
        end
        if (ncs && !p_ncs) begin
            frames.push_back('{m_sh, m_nb, m_low, m_fall, cyc});
            if (m_nb == 16 && m_sh[15] && m_sh[14:8] <= 7'd4)
                p_regs[int'(m_sh[14:8])] = m_sh[7:0];
        end
        if (copi !== p_copi && !(p_sclk && !sclk) && ncs === p_ncs)
            stab_err++;
        p_ncs = ncs;
        p_sclk = sclk;
        p_copi = copi;
    end

    task automatic cmp_regs();
        for (int i = 0; i < 5; i++)
            check($sformatf("reg%0d", i), int'(p_regs[i]), int'(m_regs[i]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", int'({ncs, sclk, copi, ack0, ack1, busy}),
              int'(6'b100000));
        rst_n = 1'b1;
        m_last = 1;
    endtask

    task automatic xact(input logic [1:0] mask,
                        input logic [6:0] a0, input logic [7:0] d0,
                        input logic [6:0] a1, input logic [7:0] d1);
        int s, t, n, first, prev_rise;
        int ord[2];
        int lat[2];
        bit got0, got1;
        frm_t f;
        logic [15:0] w;
        addr0 = a0; data0 = d0; addr1 = a1; data1 = d1;
        req0 = mask[0];
        req1 = mask[1];
        s = cyc; t = 0; first = -1; prev_rise = 0;
        lat[0] = 0; lat[1] = 0;
        got0 = !mask[0];
        got1 = !mask[1];
        if (mask == 2'b11) begin
            ord[0] = (m_last == 1) ? 0 : 1;
            ord[1] = 1 - ord[0];
            n = 2;
        end else begin
            ord[0] = mask[1] ? 1 : 0;
            ord[1] = 0;
            n = 1;
        end
        while (!(got0 && got1) && t < 4000) begin
            @(negedge clk);
            t++;
            if (t == 3 && mask != 2'b11) begin
                addr0 = 7'($urandom); data0 = 8'($urandom);
                addr1 = 7'($urandom); data1 = 8'($urandom);
            end
            if (ack0 && req0) begin
                req0 = 1'b0; got0 = 1'b1; lat[0] = cyc - s;
                if (first < 0) first = 0;
            end
            if (ack1 && req1) begin
                req1 = 1'b0; got1 = 1'b1; lat[1] = cyc - s;
                if (first < 0) first = 1;
            end
        end
        check("ack_wait", int'({got0, got1}), 3);
        check("busy_at_ack", int'(busy), 0);
        if (n == 1) begin
            check("latency", lat[ord[0]], 141);
        end else begin
            check("first_grant", first, ord[0]);
            check("lat_second", lat[ord[1]], 282);
        end
        check("frame_cnt", frames.size(), n);
        for (int i = 0; i < n && frames.size() > 0; i++) begin
            f = frames.pop_front();
            w = (ord[i] == 1) ? {1'b1, a1, d1} : {1'b1, a0, d0};
            check("frame", int'(f.w), int'(w));
            check("bits", f.nb, 16);
            check("ncs_low", f.low, 132);
            if (i == 1) check("cs_gap", f.fall - prev_rise, 9);
            prev_rise = f.rise;
        end
        for (int i = 0; i < n; i++) begin
            if (ord[i] == 1 && a1 <= 7'd4) m_regs[int'(a1)] = d1;
            if (ord[i] == 0 && a0 <= 7'd4) m_regs[int'(a0)] = d0;
        end
        m_last = ord[n-1];
        cmp_regs();
    endtask

    initial begin
        int t, rises, c0, c1, exp_first, s, lat, low;
        logic ps, got;
        logic [15:0] bsh;
        int ordq[$];
        frm_t f;
        logic [6:0] fa[2];
        logic [7:0] fd[2];

        for (int i = 0; i < 5; i++) begin
            p_regs[i] = '0;
            m_regs[i] = '0;
        end
        rst_n = 1'b0;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
        b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0;
        b_data0 = 0; b_data1 = 0;

        do_reset();

        // single write
        xact(2'b01, 7'h04, 8'hA5, 7'h00, 8'h00);
        check("duty_A5", int'(p_regs[4]), 8'hA5);

        // contention right after reset
        do_reset();
        xact(2'b11, 7'h00, 8'h3C, 7'h01, 8'hC3);
        check("en_lo_3C", int'(p_regs[0]), 8'h3C);
        check("en_hi_C3", int'(p_regs[1]), 8'hC3);

        // fairness: both held for four frames
        fa[0] = 7'h03; fd[0] = 8'($urandom);
        fa[1] = 7'h02; fd[1] = 8'($urandom);
        addr0 = fa[0]; data0 = fd[0]; addr1 = fa[1]; data1 = fd[1];
        exp_first = (m_last == 1) ? 0 : 1;
        req0 = 1'b1; req1 = 1'b1;
        c0 = 0; c1 = 0; t = 0;
        while ((c0 < 2 || c1 < 2) && t < 8000) begin
            @(negedge clk);
            t++;
            if (ack0) begin
                c0++; ordq.push_back(0);
                if (c0 == 2) req0 = 1'b0;
            end
            if (ack1) begin
                c1++; ordq.push_back(1);
                if (c1 == 2) req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("fair_ack0", c0, 2);
        check("fair_ack1", c1, 2);
        check("fair_cnt", ordq.size(), 4);
        for (int i = 0; i < 4 && ordq.size() > 0; i++) begin
            check("fair_order", ordq.pop_front(), (exp_first + i) % 2);
            if (frames.size() > 0) begin
                f = frames.pop_front();
                check("fair_frame", int'(f.w),
                      int'({1'b1, fa[(exp_first + i) % 2],
                            fd[(exp_first + i) % 2]}));
            end
            m_regs[int'(fa[(exp_first + i) % 2])] = fd[(exp_first + i) % 2];
        end
        m_last = (exp_first + 3) % 2;
        cmp_regs();

        // reset after the 8th sclk rise
        @(negedge clk);
        req0 = 1'b1; addr0 = 7'h04; data0 = 8'h5A;
        rises = 0; t = 0; ps = 1'b0;
        while (rises < 8 && t < 2000) begin
            @(negedge clk);
            t++;
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        check("rise8_wait", rises, 8);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_outs", int'({ncs, sclk, copi, busy, ack0, ack1}),
              int'(6'b100000));
        repeat (2) @(negedge clk);
        check("rst_mid_ack", int'({ack0, ack1}), 0);
        req0 = 1'b0;
        #1 rst_n = 1'b1;
        m_last = 1;
        check("partial_cnt", frames.size(), 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check("partial_bits", f.nb, 8);
        end
        cmp_regs();
        @(negedge clk);
        xact(2'b10, 7'h00, 8'h00, 7'h02, 8'hFF);
        check("pwm_lo_FF", int'(p_regs[2]), 8'hFF);

        // invalid address leaves registers alone
        xact(2'b01, 7'h7F, 8'h11, 7'h00, 8'h00);

        // randomized traffic
        for (int r = 0; r < 8; r++) begin
            xact(2'($urandom_range(1, 3)),
                 7'($urandom_range(0, 7)), 8'($urandom),
                 7'($urandom_range(0, 7)), 8'($urandom));
        end

        // HALF_PERIOD=6, CS_GAP=4 instance
        @(negedge clk);
        b_addr0 = 7'h7F; b_data0 = 8'h11; b_req0 = 1'b1;
        s = cyc; t = 0; low = 0; lat = 0; bsh = '0; ps = 1'b0; got = 1'b0;
        while (!got && t < 4000) begin
            @(negedge clk);
            t++;
            if (!b_ncs) low++;
            if (!b_ncs && b_sclk && !ps) bsh = {bsh[14:0], b_copi};
            ps = b_sclk;
            if (b_ack0) begin
                got = 1'b1; lat = cyc - s; b_req0 = 1'b0;
            end
        end
        check("b_ack_wait", int'(got), 1);
        check("b_ncs_low", low, 198);
        check("b_latency", lat, 203);
        check("b_frame", int'(bsh), 16'hFF11);

        check("copi_stable", stab_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_cfg_master.md
# spi_cfg_master

On-chip SPI controller that configures the SPI register peripheral: the output-enable, PWM-enable and PWM duty-cycle registers. It arbitrates round-robin between two on-chip write requesters. It serialises each granted write into one 16-bit mode-0 frame on SCLK/COPI/nCS, paced slowly enough for the peripheral's clk-domain synchronisers. It sits between the internal configuration sources (boot sequencer on port 0, debug/host port on port 1) and the peripheral's SPI inputs.

## Interface
Parameters:
- HALF_PERIOD, 4: clk cycles per SCLK half-period; legal range 4..255.
- CS_GAP, 8: clk cycles nCS is held high after each frame before the ack pulse; legal range 4..255.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req0 / req1, input, 1: write request; held high until the matching ack.
- addr0 / addr1, input, 7: target register address; sampled in the grant cycle.
- data0 / data1, input, 8: write data; sampled in the grant cycle.
- ack0 / ack1, output, 1: one-cycle pulse when that requester's frame has fully completed.
- busy, output, 1: high whenever the FSM is not in IDLE.
- sclk, output, 1: SPI clock, idle low.
- copi, output, 1: SPI data out, MSB first.
- ncs, output, 1: SPI chip select, active low.

## Operation
- Frame format: {1'b1, addr[6:0], data[7:0]}. Bit 15 is always 1 (write). The address is sent unchecked; out-of-range addresses are ignored by the peripheral.
- All SPI outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE:
  - If any req is high, grant, load the 16-bit shift register and go to SETUP.
  - Arbitration is round-robin on a last-grant pointer. The pointer resets to favour req0.
  - If only one req is high, it is granted immediately.
- SETUP: ncs=0, sclk=0, copi=bit15; lasts HALF_PERIOD cycles, then HIGH.
- HIGH: sclk=1 for HALF_PERIOD cycles; copi stable. After the 16th HIGH, go to HOLD; otherwise go to LOW.
- LOW: sclk=0. copi advances to the next bit on the same clk edge that drops sclk. Lasts HALF_PERIOD cycles, then HIGH.
- HOLD: sclk=0, ncs=0, copi holds bit0; lasts HALF_PERIOD cycles, then GAP.
- GAP:
  - ncs=1, copi=0; lasts CS_GAP cycles.
  - The granted ack pulses during the final GAP cycle; the FSM then returns to IDLE.
- Counters: an 8-bit half-period counter and a 5-bit rising-edge counter, 0..16. Both clear on entry to SETUP.
- req dropped mid-frame: the frame still completes and the ack still pulses. No abort path exists.
- addr/data changes after the grant cycle have no effect on the frame in flight.

## Timing
- Reset values: ncs=1, sclk=0, copi=0, ack0=ack1=0, busy=0, FSM=IDLE, pointer favours req0.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). No ack is issued. The peripheral sees fewer than 16 bits and discards the frame.
- Grant: req sampled high in IDLE at edge N gives ncs=0 and busy=1 from edge N+1.
- nCS low time is 33*HALF_PERIOD cycles (132 at the default).
- There are 16 SCLK rising edges. COPI is stable for HALF_PERIOD cycles on each side of every rising edge.
- ack pulses CS_GAP cycles after ncs rises. The earliest next ncs fall is 1 cycle after the ack, so the minimum nCS-high time is CS_GAP+1.
- Request-to-ack latency for an uncontended request: 1 + 33*HALF_PERIOD + CS_GAP cycles (141 at the defaults).
- Simultaneous req0 and req1 in IDLE: grant goes to the requester not granted last. The loser waits exactly one full frame plus one IDLE cycle.

## Test plan
- Single write: req0 with addr0=0x04, data0=0xA5.
  - Bits on copi at sclk rises read 0x84A5 MSB first.
  - ncs is low for 132 cycles; ack0 pulses once at cycle 141.
  - Peripheral model: pwm_duty_cycle=0xA5.
- Contention: req0 and req1 both raised in the first cycle after reset (addr 0x00/0x01, data 0x3C/0xC3).
  - Frame for req0 first, then req1; ncs high for exactly 9 cycles between frames.
  - Peripheral: en_reg_out_7_0=0x3C, en_reg_out_15_8=0xC3.
- Fairness: req0 and req1 held high continuously for 4 frames → grants alternate 0,1,0,1; each ack pulses exactly twice.
- Reset mid-frame: rst_n pulled low after the 8th sclk rise.
  - Immediately ncs=1, sclk=0, copi=0, busy=0, no ack; peripheral registers unchanged.
  - A following req1 write to addr 0x02, data 0xFF completes and sets en_reg_pwm_7_0=0xFF.
- Parameter and address corners: HALF_PERIOD=6, CS_GAP=4; write to addr 0x7F, data 0x11.
  - ncs low for 198 cycles, ack at cycle 203.
  - Peripheral registers unchanged (invalid address).
